// File: rtl/lab2_proc_mem_port_arbiter_pkg.sv
// Shared message, id and FSM types for the imem/dmem memory-port arbiter.
package lab2_proc_mem_arb_pkg;

   typedef struct packed {
      logic [2:0]  msg_type;
      logic [7:0]  opaque;
      logic [31:0] addr;
      logic [1:0]  len;
      logic [31:0] data;
   } mem_req_4B_t;

   typedef struct packed {
      logic [2:0]  msg_type;
      logic [7:0]  opaque;
      logic [1:0]  test;
      logic [1:0]  len;
      logic [31:0] data;
   } mem_resp_4B_t;

   typedef logic arb_id_t;

   localparam arb_id_t ARB_ID_IMEM = 1'b0;
   localparam arb_id_t ARB_ID_DMEM = 1'b1;

   typedef enum logic [0:0] {ARB_OPEN, ARB_LOCKED} arb_state_t;

   function automatic arb_id_t arb_other_id(input arb_id_t id);
      return ~id;
   endfunction

endpackage

// File: rtl/lab2_proc_mem_port_arbiter_if.sv
// Bundle of the two requester ports and the shared memory port, with arbiter/environment views.
interface lab2_proc_mem_port_arbiter_if;
   import lab2_proc_mem_arb_pkg::*;

   mem_req_4B_t  req0_msg;
   logic         req0_val;
   logic         req0_rdy;
   mem_req_4B_t  req1_msg;
   logic         req1_val;
   logic         req1_rdy;

   mem_resp_4B_t resp0_msg;
   logic         resp0_val;
   logic         resp0_rdy;
   mem_resp_4B_t resp1_msg;
   logic         resp1_val;
   logic         resp1_rdy;

   mem_req_4B_t  mem_req_msg;
   logic         mem_req_val;
   logic         mem_req_rdy;
   mem_resp_4B_t mem_resp_msg;
   logic         mem_resp_val;
   logic         mem_resp_rdy;

   // Arbiter side.
   modport master (
      input  req0_msg, req0_val, req1_msg, req1_val, resp0_rdy, resp1_rdy,
      input  mem_req_rdy, mem_resp_msg, mem_resp_val,
      output req0_rdy, req1_rdy, resp0_msg, resp0_val, resp1_msg, resp1_val,
      output mem_req_msg, mem_req_val, mem_resp_rdy
   );

   // Requester/memory side.
   modport slave (
      output req0_msg, req0_val, req1_msg, req1_val, resp0_rdy, resp1_rdy,
      output mem_req_rdy, mem_resp_msg, mem_resp_val,
      input  req0_rdy, req1_rdy, resp0_msg, resp0_val, resp1_msg, resp1_val,
      input  mem_req_msg, mem_req_val, mem_resp_rdy
   );

endinterface

// File: rtl/lab2_proc_mem_arb_id_fifo.sv
// In-order FIFO of requester ids for requests outstanding at the memory.
module lab2_proc_mem_arb_id_fifo
   import lab2_proc_mem_arb_pkg::*;
#(
   parameter int unsigned p_depth = 2
) (
   input  logic    clk,
   input  logic    reset,
   input  logic    enq_val,
   input  arb_id_t enq_id,
   input  logic    deq_val,
   output arb_id_t head_id,
   output logic    full,
   output logic    empty
);

   localparam int unsigned PtrW = (p_depth > 1) ? $clog2(p_depth) : 1;
   localparam int unsigned CntW = $clog2(p_depth + 1);
   localparam logic [PtrW-1:0] PtrLast = PtrW'(p_depth - 1);
   localparam logic [CntW-1:0] CntFull = CntW'(p_depth);

   arb_id_t         slots_q [p_depth];
   arb_id_t         slots_d [p_depth];
   logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0] count_q, count_d;

   always_comb begin
      slots_d  = slots_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (enq_val) begin
         slots_d[wr_ptr_q] = enq_id;
         wr_ptr_d = (wr_ptr_q == PtrLast) ? '0 : wr_ptr_q + 1'b1;
      end
      if (deq_val) begin
         rd_ptr_d = (rd_ptr_q == PtrLast) ? '0 : rd_ptr_q + 1'b1;
      end
      case ({enq_val, deq_val})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
      slots_q <= slots_d;
   end

   assign head_id = slots_q[rd_ptr_q];
   assign full    = (count_q == CntFull);
   assign empty   = (count_q == '0);

endmodule

// File: rtl/lab2_proc_mem_port_arbiter.sv
// Round-robin, lock-until-accepted arbiter sharing one memory port between imem and dmem.
// Optional statistics counters: LAB2_PROC_MEM_PORT_ARBITER_STATS_EN.
module lab2_proc_mem_port_arbiter
   import lab2_proc_mem_arb_pkg::*;
#(
   parameter int unsigned p_max_outstanding = 2
) (
   input  logic        clk,
   input  logic        reset,
`ifdef LAB2_PROC_MEM_PORT_ARBITER_STATS_EN
   input  logic        stats_en,
   output logic [31:0] grant_cnt0,
   output logic [31:0] grant_cnt1,
   output logic [31:0] conflict_cnt,
`endif
   lab2_proc_mem_port_arbiter_if.master bus
);

   arb_state_t state_q, state_d;
   arb_id_t    lock_id_q, lock_id_d;
   arb_id_t    prio_q, prio_d;
   arb_id_t    grant;
   arb_id_t    head_id;
   logic       grant_val;
   logic       req_fire;
   logic       resp_fire;
   logic       fifo_full;
   logic       fifo_empty;

   // Grant never looks at mem_req_rdy, so the memory sees a stable request while it stalls.
   always_comb begin
      if (state_q == ARB_LOCKED) begin
         grant = lock_id_q;
      end else if (bus.req0_val != bus.req1_val) begin
         grant = bus.req1_val ? ARB_ID_DMEM : ARB_ID_IMEM;
      end else begin
         grant = prio_q;
      end
   end

   assign grant_val       = (grant == ARB_ID_DMEM) ? bus.req1_val : bus.req0_val;
   assign bus.mem_req_val = grant_val & ~fifo_full;
   assign bus.mem_req_msg = (grant == ARB_ID_DMEM) ? bus.req1_msg : bus.req0_msg;
   assign bus.req0_rdy    = (grant == ARB_ID_IMEM) & bus.mem_req_rdy & ~fifo_full;
   assign bus.req1_rdy    = (grant == ARB_ID_DMEM) & bus.mem_req_rdy & ~fifo_full;
   assign req_fire        = bus.mem_req_val & bus.mem_req_rdy;

   always_comb begin
      state_d   = state_q;
      lock_id_d = lock_id_q;
      unique case (state_q)
         ARB_OPEN: begin
            if (bus.mem_req_val && !bus.mem_req_rdy) begin
               state_d   = ARB_LOCKED;
               lock_id_d = grant;
            end
         end
         ARB_LOCKED: begin
            if (req_fire) state_d = ARB_OPEN;
         end
         default: state_d = ARB_OPEN;
      endcase
      prio_d = req_fire ? arb_other_id(grant) : prio_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ARB_OPEN;
         lock_id_q <= ARB_ID_IMEM;
         prio_q    <= ARB_ID_IMEM;
      end else begin
         state_q   <= state_d;
         lock_id_q <= lock_id_d;
         prio_q    <= prio_d;
      end
   end

   lab2_proc_mem_arb_id_fifo #(
      .p_depth (p_max_outstanding)
   ) u_id_fifo (
      .clk     (clk),
      .reset   (reset),
      .enq_val (req_fire),
      .enq_id  (grant),
      .deq_val (resp_fire),
      .head_id (head_id),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   // Responses follow the oldest outstanding id; a stray response with no id is held off.
   assign bus.resp0_msg    = bus.mem_resp_msg;
   assign bus.resp1_msg    = bus.mem_resp_msg;
   assign bus.resp0_val    = bus.mem_resp_val & ~fifo_empty & (head_id == ARB_ID_IMEM);
   assign bus.resp1_val    = bus.mem_resp_val & ~fifo_empty & (head_id == ARB_ID_DMEM);
   assign bus.mem_resp_rdy = ((head_id == ARB_ID_DMEM) ? bus.resp1_rdy : bus.resp0_rdy)
                             & ~fifo_empty;
   assign resp_fire        = bus.mem_resp_val & bus.mem_resp_rdy;

`ifndef SYNTHESIS
   always @(posedge clk) begin
      if (!reset && bus.mem_resp_val && fifo_empty) begin
         $error("mem response arrived with no outstanding request");
      end
   end
`endif

`ifdef LAB2_PROC_MEM_PORT_ARBITER_STATS_EN
   logic [31:0] grant_cnt0_q, grant_cnt0_d;
   logic [31:0] grant_cnt1_q, grant_cnt1_d;
   logic [31:0] conflict_cnt_q, conflict_cnt_d;

   always_comb begin
      grant_cnt0_d   = grant_cnt0_q;
      grant_cnt1_d   = grant_cnt1_q;
      conflict_cnt_d = conflict_cnt_q;
      if (stats_en && req_fire) begin
         if (grant == ARB_ID_DMEM) grant_cnt1_d = grant_cnt1_q + 32'd1;
         else                      grant_cnt0_d = grant_cnt0_q + 32'd1;
      end
      if (stats_en && bus.req0_val && bus.req1_val) begin
         conflict_cnt_d = conflict_cnt_q + 32'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         grant_cnt0_q   <= '0;
         grant_cnt1_q   <= '0;
         conflict_cnt_q <= '0;
      end else begin
         grant_cnt0_q   <= grant_cnt0_d;
         grant_cnt1_q   <= grant_cnt1_d;
         conflict_cnt_q <= conflict_cnt_d;
      end
   end

   assign grant_cnt0   = grant_cnt0_q;
   assign grant_cnt1   = grant_cnt1_q;
   assign conflict_cnt = conflict_cnt_q;
`endif

endmodule

// File: tb/tb_lab2_proc_mem_port_arbiter.sv
// Scoreboard bench for the imem/dmem memory-port arbiter with a latency-1 in-order memory model.
module tb_lab2_proc_mem_port_arbiter;
   import lab2_proc_mem_arb_pkg::*;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   lab2_proc_mem_port_arbiter_if bus ();

`ifdef LAB2_PROC_MEM_PORT_ARBITER_STATS_EN
   logic        stats_en;
   logic [31:0] grant_cnt0, grant_cnt1, conflict_cnt;
`endif

   lab2_proc_mem_port_arbiter #(
      .p_max_outstanding (2)
   ) dut (
      .clk          (clk),
      .reset        (reset),
`ifdef LAB2_PROC_MEM_PORT_ARBITER_STATS_EN
      .stats_en     (stats_en),
      .grant_cnt0   (grant_cnt0),
      .grant_cnt1   (grant_cnt1),
      .conflict_cnt (conflict_cnt),
`endif
      .bus          (bus)
   );

   int checks = 0;
   int errors = 0;
   int seq = 0;

   mem_req_4B_t  src0_q[$], src1_q[$];
   mem_resp_4B_t exp0_q[$], exp1_q[$], pipe_q[$];
   arb_id_t      grant_log[$];
   logic [7:0]   resp_log[$];
   mem_resp_4B_t mon_exp;

   logic mem_rdy_ctl, resp0_rdy_ctl, resp1_rdy_ctl, mem_hold;
   int   resp0_fires, resp1_fires, resp1_seen;
   int   mdl_g0, mdl_g1, mdl_conf;

   // Memory behaviour: echoes type/opaque/len, data derived from address and write data.
   function automatic mem_resp_4B_t mem_model(input mem_req_4B_t r);
      mem_resp_4B_t p;
      p.msg_type = r.msg_type;
      p.opaque   = r.opaque;
      p.test     = 2'b00;
      p.len      = r.len;
      p.data     = {r.addr[15:0], 16'h0000} ^ r.data;
      return p;
   endfunction

   task automatic push_req(input arb_id_t id, input logic [31:0] addr, output mem_req_4B_t r);
      r.msg_type = 3'd0;
      r.opaque   = {id, seq[6:0]};
      r.addr     = addr;
      r.len      = 2'd0;
      r.data     = $urandom;
      seq++;
      if (id == ARB_ID_DMEM) begin
         src1_q.push_back(r);
         exp1_q.push_back(mem_model(r));
      end else begin
         src0_q.push_back(r);
         exp0_q.push_back(mem_model(r));
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
      #1;
   endtask

   task automatic wait_idle(input string name, input int budget);
      int k = 0;
      while ((src0_q.size() + src1_q.size() + pipe_q.size() + exp0_q.size() + exp1_q.size()) != 0
             && k < budget) begin
         step(1);
         k++;
      end
      checks++;
      if ((src0_q.size() + src1_q.size() + pipe_q.size() + exp0_q.size() + exp1_q.size()) != 0)
      begin
         errors++;
         $display("FAIL %s_drain: %0d items outstanding, required 0", name,
                  src0_q.size() + src1_q.size() + pipe_q.size() + exp0_q.size() + exp1_q.size());
      end
   endtask

   // Input drivers: update just after each rising edge.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         bus.req0_val = (src0_q.size() != 0);
         if (src0_q.size() != 0) bus.req0_msg = src0_q[0];
         bus.req1_val = (src1_q.size() != 0);
         if (src1_q.size() != 0) bus.req1_msg = src1_q[0];
         bus.mem_req_rdy  = mem_rdy_ctl;
         bus.resp0_rdy    = resp0_rdy_ctl;
         bus.resp1_rdy    = resp1_rdy_ctl;
         bus.mem_resp_val = !mem_hold && (pipe_q.size() != 0);
         if (pipe_q.size() != 0) bus.mem_resp_msg = pipe_q[0];
      end
   end

   // Monitor, memory model and response scoreboard: sample on the falling edge.
   initial begin
      forever begin
         @(negedge clk);
         if (reset !== 1'b1) begin
            if (bus.req0_val && bus.req0_rdy) void'(src0_q.pop_front());
            if (bus.req1_val && bus.req1_rdy) void'(src1_q.pop_front());
            if (bus.mem_resp_val && bus.mem_resp_rdy) void'(pipe_q.pop_front());
            if (bus.mem_req_val && bus.mem_req_rdy) begin
               grant_log.push_back(bus.mem_req_msg.opaque[7]);
               pipe_q.push_back(mem_model(bus.mem_req_msg));
               if (bus.mem_req_msg.opaque[7]) mdl_g1++;
               else                           mdl_g0++;
            end
            if (bus.req0_val && bus.req1_val) mdl_conf++;
            if (bus.resp1_val) resp1_seen++;
            if (bus.resp0_val && bus.resp1_val) begin
               checks++;
               errors++;
               $display("FAIL resp_onehot: resp0_val=1 resp1_val=1, required at most one");
            end
            if (bus.resp0_val && bus.resp0_rdy) begin
               checks++;
               resp0_fires++;
               resp_log.push_back(bus.resp0_msg.opaque);
               if (exp0_q.size() == 0) begin
                  errors++;
                  $display("FAIL resp0_unexpected: got %h, required none", bus.resp0_msg);
               end else begin
                  mon_exp = exp0_q.pop_front();
                  if (bus.resp0_msg !== mon_exp) begin
                     errors++;
                     $display("FAIL resp0_msg: got %h, required %h", bus.resp0_msg, mon_exp);
                  end
               end
            end
            if (bus.resp1_val && bus.resp1_rdy) begin
               checks++;
               resp1_fires++;
               resp_log.push_back(bus.resp1_msg.opaque);
               if (exp1_q.size() == 0) begin
                  errors++;
                  $display("FAIL resp1_unexpected: got %h, required none", bus.resp1_msg);
               end else begin
                  mon_exp = exp1_q.pop_front();
                  if (bus.resp1_msg !== mon_exp) begin
                     errors++;
                     $display("FAIL resp1_msg: got %h, required %h", bus.resp1_msg, mon_exp);
                  end
               end
            end
         end
      end
   end

   task automatic test_reset();
      reset         = 1'b1;
      mem_rdy_ctl   = 1'b0;
      resp0_rdy_ctl = 1'b1;
      resp1_rdy_ctl = 1'b1;
      mem_hold      = 1'b0;
      step(2);
      checks++;
      if ({bus.mem_req_val, bus.req0_rdy, bus.req1_rdy} !== 3'b000) begin
         errors++;
         $display("FAIL reset_req: mem_req_val/req0_rdy/req1_rdy=%b, required 000",
                  {bus.mem_req_val, bus.req0_rdy, bus.req1_rdy});
      end
      checks++;
      if ({bus.resp0_val, bus.resp1_val, bus.mem_resp_rdy} !== 3'b000) begin
         errors++;
         $display("FAIL reset_resp: resp0_val/resp1_val/mem_resp_rdy=%b, required 000",
                  {bus.resp0_val, bus.resp1_val, bus.mem_resp_rdy});
      end
`ifdef LAB2_PROC_MEM_PORT_ARBITER_STATS_EN
      checks++;
      if ({grant_cnt0, grant_cnt1, conflict_cnt} !== 96'd0) begin
         errors++;
         $display("FAIL reset_stats: %0d %0d %0d, required 0 0 0",
                  grant_cnt0, grant_cnt1, conflict_cnt);
      end
`endif
      reset = 1'b0;
      step(1);
   endtask

   task automatic test_single();
      mem_req_4B_t r;
      mem_rdy_ctl = 1'b1;
      resp1_seen  = 0;
      resp0_fires = 0;
      push_req(ARB_ID_IMEM, 32'h0000_0200, r);
      step(1);
      checks++;
      if ({bus.mem_req_val, bus.req0_rdy, bus.req1_rdy} !== 3'b110) begin
         errors++;
         $display("FAIL single_handshake: mem_req_val/req0_rdy/req1_rdy=%b, required 110",
                  {bus.mem_req_val, bus.req0_rdy, bus.req1_rdy});
      end
      checks++;
      if (bus.mem_req_msg.addr !== 32'h0000_0200) begin
         errors++;
         $display("FAIL single_addr: got %h, required 00000200", bus.mem_req_msg.addr);
      end
      checks++;
      if (bus.mem_req_msg !== r) begin
         errors++;
         $display("FAIL single_msg: got %h, required %h", bus.mem_req_msg, r);
      end
      wait_idle("single", 20);
      checks++;
      if (resp0_fires != 1 || resp1_seen != 0) begin
         errors++;
         $display("FAIL single_route: resp0 fires=%0d resp1_val cycles=%0d, required 1 and 0",
                  resp0_fires, resp1_seen);
      end
   endtask

   task automatic test_alternate();
      mem_req_4B_t r;
      grant_log.delete();
      for (int i = 0; i < 4; i++) begin
         push_req(ARB_ID_IMEM, 32'h1000 + 32'(i * 4), r);
         push_req(ARB_ID_DMEM, 32'h2000 + 32'(i * 4), r);
      end
      wait_idle("alternate", 40);
      checks++;
      if (grant_log.size() != 8) begin
         errors++;
         $display("FAIL alt_count: %0d grants, required 8", grant_log.size());
      end else begin
         // The single imem grant before this left priority with dmem.
         for (int i = 0; i < 8; i++) begin
            checks++;
            if (grant_log[i] !== arb_id_t'(i % 2 == 0)) begin
               errors++;
               $display("FAIL alt_grant%0d: got %0d, required %0d", i, grant_log[i], (i % 2 == 0));
            end
         end
      end
   endtask

   task automatic test_lock();
      mem_req_4B_t ra, rb, rs;
      mem_rdy_ctl = 1'b1;
      push_req(ARB_ID_DMEM, 32'h0000_0300, rs);
      wait_idle("lock_setup", 20);
      grant_log.delete();
      mem_rdy_ctl = 1'b0;
      push_req(ARB_ID_DMEM, 32'h0000_0304, ra);
      step(1);
      checks++;
      if (bus.mem_req_val !== 1'b1 || bus.mem_req_msg !== ra) begin
         errors++;
         $display("FAIL lock_c0: val=%b msg=%h, required 1 %h", bus.mem_req_val, bus.mem_req_msg, ra);
      end
      push_req(ARB_ID_IMEM, 32'h0000_0308, rb);
      for (int c = 1; c <= 2; c++) begin
         step(1);
         checks++;
         if (bus.mem_req_msg !== ra || bus.req0_rdy !== 1'b0 || bus.req1_rdy !== 1'b0) begin
            errors++;
            $display("FAIL lock_c%0d: msg=%h rdy0=%b rdy1=%b, required %h 0 0", c,
                     bus.mem_req_msg, bus.req0_rdy, bus.req1_rdy, ra);
         end
      end
      mem_rdy_ctl = 1'b1;
      step(1);
      checks++;
      if (bus.mem_req_msg !== ra || bus.req1_rdy !== 1'b1) begin
         errors++;
         $display("FAIL lock_accept: msg=%h rdy1=%b, required %h 1", bus.mem_req_msg, bus.req1_rdy, ra);
      end
      step(1);
      checks++;
      if (bus.mem_req_msg !== rb || bus.req0_rdy !== 1'b1) begin
         errors++;
         $display("FAIL lock_next: msg=%h rdy0=%b, required %h 1", bus.mem_req_msg, bus.req0_rdy, rb);
      end
      wait_idle("lock", 20);
      checks++;
      if (grant_log.size() != 2 || grant_log[0] !== ARB_ID_DMEM || grant_log[1] !== ARB_ID_IMEM)
      begin
         errors++;
         $display("FAIL lock_order: %0d grants, required dmem then imem", grant_log.size());
      end
   endtask

   task automatic test_full();
      mem_req_4B_t r0, r1, r2;
      mem_rdy_ctl = 1'b1;
      mem_hold    = 1'b1;
      push_req(ARB_ID_IMEM, 32'h0000_0400, r0);
      push_req(ARB_ID_IMEM, 32'h0000_0404, r1);
      push_req(ARB_ID_IMEM, 32'h0000_0408, r2);
      step(1);
      step(1);
      checks++;
      if (bus.mem_req_val !== 1'b1 || bus.mem_req_msg !== r1) begin
         errors++;
         $display("FAIL full_second: val=%b msg=%h, required 1 %h", bus.mem_req_val, bus.mem_req_msg, r1);
      end
      for (int c = 2; c <= 3; c++) begin
         step(1);
         checks++;
         if ({bus.mem_req_val, bus.req0_rdy, bus.req1_rdy} !== 3'b000) begin
            errors++;
            $display("FAIL full_stall_c%0d: val/rdy0/rdy1=%b, required 000", c,
                     {bus.mem_req_val, bus.req0_rdy, bus.req1_rdy});
         end
      end
      mem_hold = 1'b0;
      step(1);
      checks++;
      if (bus.mem_resp_rdy !== 1'b1 || bus.mem_req_val !== 1'b0) begin
         errors++;
         $display("FAIL full_deq_cycle: mem_resp_rdy=%b mem_req_val=%b, required 1 0",
                  bus.mem_resp_rdy, bus.mem_req_val);
      end
      step(1);
      checks++;
      if (bus.mem_req_val !== 1'b1 || bus.mem_req_msg !== r2) begin
         errors++;
         $display("FAIL full_resume: val=%b msg=%h, required 1 %h", bus.mem_req_val, bus.mem_req_msg, r2);
      end
      wait_idle("full", 20);
   endtask

   task automatic test_resp_order();
      mem_req_4B_t ra, rb;
      mem_rdy_ctl   = 1'b1;
      resp1_rdy_ctl = 1'b0;
      resp_log.delete();
      push_req(ARB_ID_DMEM, 32'h0000_0500, ra);
      step(1);
      push_req(ARB_ID_IMEM, 32'h0000_0504, rb);
      step(1);
      for (int c = 2; c <= 3; c++) begin
         step(1);
         checks++;
         if ({bus.resp1_val, bus.mem_resp_rdy, bus.resp0_val} !== 3'b100) begin
            errors++;
            $display("FAIL order_hold_c%0d: resp1_val/mem_resp_rdy/resp0_val=%b, required 100", c,
                     {bus.resp1_val, bus.mem_resp_rdy, bus.resp0_val});
         end
      end
      resp1_rdy_ctl = 1'b1;
      wait_idle("order", 20);
      checks++;
      if (resp_log.size() != 2 || resp_log[0] !== ra.opaque || resp_log[1] !== rb.opaque) begin
         errors++;
         $display("FAIL order_seq: %0d responses, required dmem %h then imem %h",
                  resp_log.size(), ra.opaque, rb.opaque);
      end
   endtask

`ifdef LAB2_PROC_MEM_PORT_ARBITER_STATS_EN
   task automatic test_stats();
      checks++;
      if (grant_cnt0 !== 32'(mdl_g0) || grant_cnt1 !== 32'(mdl_g1) || conflict_cnt !== 32'(mdl_conf))
      begin
         errors++;
         $display("FAIL stats_counts: %0d %0d %0d, required %0d %0d %0d",
                  grant_cnt0, grant_cnt1, conflict_cnt, mdl_g0, mdl_g1, mdl_conf);
      end
   endtask
`endif

   task automatic test_reset_mid();
      mem_req_4B_t r;
      mem_rdy_ctl = 1'b1;
      mem_hold    = 1'b1;
      push_req(ARB_ID_IMEM, 32'h0000_0600, r);
      push_req(ARB_ID_DMEM, 32'h0000_0604, r);
      step(3);
      // Memory and requesters are reset together with the arbiter.
      reset       = 1'b1;
      mem_rdy_ctl = 1'b0;
      src0_q.delete();
      src1_q.delete();
      exp0_q.delete();
      exp1_q.delete();
      pipe_q.delete();
      mdl_g0   = 0;
      mdl_g1   = 0;
      mdl_conf = 0;
      step(1);
      checks++;
      if ({bus.mem_req_val, bus.req0_rdy, bus.req1_rdy, bus.resp0_val, bus.resp1_val,
           bus.mem_resp_rdy} !== 6'b000000) begin
         errors++;
         $display("FAIL rst_mid_vals: val/rdy outputs=%b, required 000000",
                  {bus.mem_req_val, bus.req0_rdy, bus.req1_rdy, bus.resp0_val, bus.resp1_val,
                   bus.mem_resp_rdy});
      end
`ifdef LAB2_PROC_MEM_PORT_ARBITER_STATS_EN
      checks++;
      if ({grant_cnt0, grant_cnt1, conflict_cnt} !== 96'd0) begin
         errors++;
         $display("FAIL rst_mid_stats: %0d %0d %0d, required 0 0 0",
                  grant_cnt0, grant_cnt1, conflict_cnt);
      end
`endif
      reset       = 1'b0;
      mem_rdy_ctl = 1'b1;
      push_req(ARB_ID_IMEM, 32'h0000_0700, r);
      push_req(ARB_ID_IMEM, 32'h0000_0704, r);
      for (int c = 0; c < 2; c++) begin
         step(1);
         checks++;
         if (bus.mem_req_val !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_accept%0d: mem_req_val=%b, required 1 (id FIFO emptied)", c,
                     bus.mem_req_val);
         end
      end
      mem_hold = 1'b0;
      wait_idle("reset_mid", 20);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      reset            = 1'b1;
      bus.req0_val     = 1'b0;
      bus.req1_val     = 1'b0;
      bus.req0_msg     = '0;
      bus.req1_msg     = '0;
      bus.mem_req_rdy  = 1'b0;
      bus.resp0_rdy    = 1'b0;
      bus.resp1_rdy    = 1'b0;
      bus.mem_resp_val = 1'b0;
      bus.mem_resp_msg = '0;
      mem_rdy_ctl      = 1'b0;
      resp0_rdy_ctl    = 1'b1;
      resp1_rdy_ctl    = 1'b1;
      mem_hold         = 1'b0;
      resp0_fires      = 0;
      resp1_fires      = 0;
      resp1_seen       = 0;
      mdl_g0           = 0;
      mdl_g1           = 0;
      mdl_conf         = 0;
`ifdef LAB2_PROC_MEM_PORT_ARBITER_STATS_EN
      stats_en = 1'b1;
`endif
      test_reset();
      test_single();
      test_alternate();
      test_lock();
      test_full();
      test_resp_order();
`ifdef LAB2_PROC_MEM_PORT_ARBITER_STATS_EN
      test_stats();
`endif
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
